serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 169 ++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial add/subtract sequencer. A single external combinational full-adder
// cell is time-shared over WIDTH clock cycles, LSB first, to build a WIDTH-bit
// sum or difference.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start               : request; sampled only while idle
//   sub, cin            : 0 = a+b+cin, 1 = a-b (cin ignored)
//   op_a, op_b          : operands, captured when start is accepted
//   busy                : high whenever the sequencer is not idle
//   done                : one-cycle pulse, result/cout/ovf valid
//   result, cout, ovf   : sum/difference, MSB carry-out (1 = no borrow on sub),
//                         signed overflow; held until the next operation ends
//   fa_a, fa_b, fa_c    : drive to the full-adder cell inputs
//   fa_s, fa_o          : sum and carry back from the full-adder cell
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_s,
    input  logic             fa_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             ovf_r;
    logic             last_bit_s;

    // The MSB is being processed in the current RUN cycle.
    assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: start only honoured in IDLE, DONE always lasts one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand capture, bit-serial shifting and final result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_sh_r <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b, seed carry with 1.
                        a_sh_r  <= op_a;
                        b_sh_r  <= sub ? ~op_b : op_b;
                        carry_r <= sub ? 1'b1 : cin;
                        cnt_r   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_sh_r <= {fa_s, res_sh_r[WIDTH-1:1]};
                    carry_r  <= fa_o;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        result_r <= {fa_s, res_sh_r[WIDTH-1:1]};
                        cout_r   <= fa_o;
                        // carry_r here is the carry into the MSB.
                        ovf_r    <= carry_r ^ fa_o;
                    end
                end
                ST_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    // Output decode; all terms come straight from flops.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        fa_a = 1'b0;
        fa_b = 1'b0;
        fa_c = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_RUN: begin
                busy = 1'b1;
                fa_a = a_sh_r[0];
                fa_b = b_sh_r[0];
                fa_c = carry_r;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign result = result_r;
    assign cout   = cout_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH = 8) with a behavioural
// full-adder cell attached and a reference add/subtract model.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic       cin;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       ovf;
    logic       fa_a;
    logic       fa_b;
    logic       fa_c;
    logic       fa_s;
    logic       fa_o;

    int n_checks;
    int n_fail;

    serial_add_ctrl #(.WIDTH(8), .CW(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .cin    (cin),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .fa_a   (fa_a),
        .fa_b   (fa_b),
        .fa_c   (fa_c),
        .fa_s   (fa_s),
        .fa_o   (fa_o)
    );

    // External full-adder cell.
    assign fa_s = fa_a ^ fa_b ^ fa_c;
    assign fa_o = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {ovf, cout, result}.
    function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic s, input logic c);
        logic [7:0] bb;
        logic [8:0] sum9;
        logic       ov;
        bb   = s ? ~b : b;
        sum9 = {1'b0, a} + {1'b0, bb} + {8'd0, (s ? 1'b1 : c)};
        ov   = (a[7] == bb[7]) && (sum9[7] != a[7]);
        return {ov, sum9};
    endfunction

    // Runs one operation; optionally pulses a stray start at negedge ign_k
    // (k counts negedges after the accepting edge, k = 0 first).
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic c, input int ign_k,
                         output int lat, output int nbusy, output int ndone,
                         output logic [7:0] mid_res);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; nbusy = 0; ndone = 0; mid_res = 8'd0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (k == 4) mid_res = result;
            if (k == ign_k) begin
                op_a = ~a; op_b = a; sub = ~s; cin = ~c; start = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic s, input logic c, input int ign_k,
                            input logic timing);
        int         lat, nbusy, ndone;
        logic [7:0] mid_res, prev;
        logic [9:0] e;
        prev = result;
        e    = ref_op(a, b, s, c);
        do_op(a, b, s, c, ign_k, lat, nbusy, ndone, mid_res);
        check_eq({tag, "_result"}, {24'd0, result}, {24'd0, e[7:0]});
        check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, e[8]});
        check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e[9]});
        if (timing) begin
            check_eq({tag, "_latency"}, lat, 32'd8);
            check_eq({tag, "_ndone"}, ndone, 32'd1);
            check_eq({tag, "_nbusy"}, nbusy, 32'd9);
            check_eq({tag, "_held"}, {24'd0, mid_res}, {24'd0, prev});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = 8'd0; op_b = 8'd0;
        #12;
        check_eq("reset_outs", {19'd0, busy, done, result, cout, ovf, fa_a, fa_b, fa_c},
                 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed expectations.
        check_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, -1, 1'b1);
        check_eq("add_5a_3c_val", {22'd0, ovf, cout, result}, {22'd0, 1'b1, 1'b0, 8'h96});
        check_op("add_ff_00_c1", 8'hFF, 8'h00, 1'b0, 1'b1, -1, 1'b1);
        check_eq("add_ff_00_val", {22'd0, ovf, cout, result}, {22'd0, 1'b0, 1'b1, 8'h00});
        check_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, -1, 1'b1);
        check_eq("add_7f_01_val", {22'd0, ovf, cout, result}, {22'd0, 1'b1, 1'b0, 8'h80});
        check_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b0, -1, 1'b1);
        check_eq("sub_10_20_val", {22'd0, ovf, cout, result}, {22'd0, 1'b0, 1'b0, 8'hF0});
        check_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, -1, 1'b1);
        check_eq("sub_80_01_val", {22'd0, ovf, cout, result}, {22'd0, 1'b1, 1'b1, 8'h7F});

        // Stray start during RUN, then during DONE: both ignored.
        check_op("ign_run", 8'h21, 8'h43, 1'b0, 1'b0, 3, 1'b1);
        check_eq("ign_run_val", {24'd0, result}, {24'd0, 8'h64});
        check_op("ign_done", 8'h33, 8'h11, 1'b1, 1'b0, 8, 1'b1);
        check_eq("ign_done_val", {24'd0, result}, {24'd0, 8'h22});
        check_eq("ign_done_idle", {31'd0, busy}, 32'd0);
        check_op("after_ign", 8'h01, 8'hFE, 1'b0, 1'b1, -1, 1'b1);

        // Reset in the middle of a RUN.
        @(negedge clk);
        op_a = 8'hC3; op_b = 8'h5A; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_outs", {19'd0, busy, done, result, cout, ovf, fa_a, fa_b, fa_c},
                 32'd0);
        @(negedge clk);
        check_eq("rst_no_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        check_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, -1, 1'b1);
        check_eq("post_rst_val", {24'd0, result}, {24'd0, 8'h02});

        // Model sweep over spread operand patterns and all sub/cin combinations.
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] a, b;
            a = 8'(i * 37 + 3);
            b = 8'(i * 113 + (i >> 5));
            check_op("sweep", a, b, i[0], i[1], -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
